gate_sweep_ctrl: RTL and testbench

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

---
 rtl/gate_sweep_ctrl.sv | 178 +++++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Purpose : walks a 2-input gate datapath through all four input vectors and
//           compares each sampled output byte against the known-good truth table.
// Latency : start accepted at edge k -> done pulse in the cycle after edge k+4*(SETTLE+1).
// Backpressure: none; start is ignored while busy or in DONE, abort cancels a sweep.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        sweep request (IDLE only), sweep cancel (busy only)
//   gate_a, gate_b      registered vector driven into the gate datapath
//   gate_o[7:0]         gate outputs, bit0=AND ... bit7=NOT b
//   busy, done          sweep in progress, one-cycle completion pulse
//   results_valid, pass result qualifier and zero-mismatch flag
//   fail_mask, err_count, table_out   accumulated sweep results
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        gate_a,
    output logic        gate_b,
    input  logic [7:0]  gate_o,
    output logic        busy,
    output logic        done,
    output logic        results_valid,
    output logic        pass,
    output logic [7:0]  fail_mask,
    output logic [2:0]  err_count,
    output logic [31:0] table_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // With SETTLE=0 the settle phase is skipped and each vector is sampled
    // in the cycle right after it is applied.
    localparam state_t     LP_FIRST  = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
    localparam logic [3:0] LP_RELOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    function automatic logic [7:0] golden(input logic [1:0] v);
        logic [7:0] g;
        case (v)
            2'd0:    g = 8'hEC;
            2'd1:    g = 8'h56;
            2'd2:    g = 8'h96;
            default: g = 8'h23;
        endcase
        return g;
    endfunction

    state_t      r_state, w_state;
    logic [1:0]  r_v, w_v;
    logic [3:0]  r_cnt, w_cnt;
    logic        r_gate_a, w_gate_a;
    logic        r_gate_b, w_gate_b;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_rv, w_rv;
    logic        r_pass, w_pass;
    logic [7:0]  r_fail, w_fail;
    logic [2:0]  r_err, w_err;
    logic [31:0] r_table, w_table;
    logic [7:0]  w_diff;
    logic [2:0]  w_err_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_v      <= 2'd0;
            r_cnt    <= 4'd0;
            r_gate_a <= 1'b0;
            r_gate_b <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rv     <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 8'd0;
            r_err    <= 3'd0;
            r_table  <= 32'd0;
        end else begin
            r_state  <= w_state;
            r_v      <= w_v;
            r_cnt    <= w_cnt;
            r_gate_a <= w_gate_a;
            r_gate_b <= w_gate_b;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_rv     <= w_rv;
            r_pass   <= w_pass;
            r_fail   <= w_fail;
            r_err    <= w_err;
            r_table  <= w_table;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_v       = r_v;
        w_cnt     = r_cnt;
        w_done    = 1'b0;
        w_rv      = r_rv;
        w_pass    = r_pass;
        w_fail    = r_fail;
        w_err     = r_err;
        w_table   = r_table;
        w_diff    = gate_o ^ golden(r_v);
        w_err_inc = r_err + {2'b00, |w_diff};

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = LP_FIRST;
                    w_v     = 2'd0;
                    w_cnt   = LP_RELOAD;
                    w_table = 32'd0;
                    w_fail  = 8'd0;
                    w_err   = 3'd0;
                    w_pass  = 1'b0;
                    w_rv    = 1'b0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    w_state = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state = S_SAMPLE;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_SAMPLE: begin
                // abort takes priority: the vector in flight leaves no trace
                if (abort) begin
                    w_state = S_IDLE;
                end else begin
                    w_table[{r_v, 3'b000} +: 8] = gate_o;
                    w_fail = r_fail | w_diff;
                    w_err  = w_err_inc;
                    if (r_v == 2'd3) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                        w_rv    = 1'b1;
                        w_pass  = (w_err_inc == 3'd0);
                    end else begin
                        w_v     = r_v + 2'd1;
                        w_cnt   = LP_RELOAD;
                        w_state = LP_FIRST;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Gate inputs and busy follow the next state so the vector changes on
        // the same edge as v and is held for the whole dwell.
        w_busy   = (w_state == S_SETTLE) || (w_state == S_SAMPLE);
        w_gate_a = w_busy & w_v[1];
        w_gate_b = w_busy & w_v[0];
    end

    assign gate_a        = r_gate_a;
    assign gate_b        = r_gate_b;
    assign busy          = r_busy;
    assign done          = r_done;
    assign results_valid = r_rv;
    assign pass          = r_pass;
    assign fail_mask     = r_fail;
    assign err_count     = r_err;
    assign table_out     = r_table;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
module tb_gate_sweep_ctrl;

    localparam int S0 = 2;
    localparam int S1 = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start  [2];
    logic        abort  [2];
    logic        gate_a [2];
    logic        gate_b [2];
    logic [7:0]  gate_o [2];
    logic        busy   [2];
    logic        done   [2];
    logic        rv     [2];
    logic        pss    [2];
    logic [7:0]  fmask  [2];
    logic [2:0]  errc   [2];
    logic [31:0] tbl    [2];
    logic [7:0]  sa0    [2];
    logic [7:0]  sa1    [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural gate datapath: bit0 AND, OR, NAND, NOR, XOR, XNOR, NOT a, bit7 NOT b.
    function automatic logic [7:0] gate_fn(input logic a, input logic b);
        return {~b, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    assign gate_o[0] = (gate_fn(gate_a[0], gate_b[0]) & ~sa0[0]) | sa1[0];
    assign gate_o[1] = (gate_fn(gate_a[1], gate_b[1]) & ~sa0[1]) | sa1[1];

    gate_sweep_ctrl #(.SETTLE(S0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .gate_a(gate_a[0]), .gate_b(gate_b[0]), .gate_o(gate_o[0]),
        .busy(busy[0]), .done(done[0]), .results_valid(rv[0]), .pass(pss[0]),
        .fail_mask(fmask[0]), .err_count(errc[0]), .table_out(tbl[0])
    );

    gate_sweep_ctrl #(.SETTLE(S1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .gate_a(gate_a[1]), .gate_b(gate_b[1]), .gate_o(gate_o[1]),
        .busy(busy[1]), .done(done[1]), .results_valid(rv[1]), .pass(pss[1]),
        .fail_mask(fmask[1]), .err_count(errc[1]), .table_out(tbl[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [48:0] outs(input int d);
        return {gate_a[d], gate_b[d], busy[d], done[d], rv[d], pss[d],
                fmask[d], errc[d], tbl[d]};
    endfunction

    // Reference: expected sweep results for a gate with stuck-at masks.
    task automatic model(input logic [7:0] f0, input logic [7:0] f1,
                         output logic [31:0] t, output logic [7:0] fm,
                         output logic [2:0] ec, output logic p);
        logic [7:0] ideal;
        logic [7:0] got;
        logic [1:0] vv;
        t = 32'd0; fm = 8'd0; ec = 3'd0;
        for (int v = 0; v < 4; v++) begin
            vv    = 2'(v);
            ideal = gate_fn(vv[1], vv[0]);
            got   = (ideal & ~f0) | f1;
            t[v*8 +: 8] = got;
            fm = fm | (got ^ ideal);
            if (got != ideal) ec = ec + 3'd1;
        end
        p = (ec == 3'd0);
    endtask

    // One full sweep on DUT d; pulse_at >= 0 raises start for one cycle mid-sweep.
    task automatic sweep(input int d, input int pulse_at, input string tag,
                         input logic [31:0] e_tbl, input logic [7:0] e_fm,
                         input logic [2:0] e_err, input logic e_pass);
        int lat, nbusy, exp_lat;
        logic [7:0] vseq;
        exp_lat = (d == 0) ? 4 * (S0 + 1) : 4 * (S1 + 1);
        lat = -1; nbusy = 0; vseq = 8'd0;
        @(negedge clk); start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            start[d] = (j == pulse_at);
            if (j == 0) check({tag, "_rv_cleared"}, {rv[d], pss[d]}, 0);
            if (j < 4) vseq = {vseq[5:0], gate_a[d], gate_b[d]};
            if (done[d]) begin
                lat = j;
                break;
            end
            if (busy[d]) nbusy++;
        end
        start[d] = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, nbusy, exp_lat);
        check({tag, "_rv"}, rv[d], 1);
        check({tag, "_pass"}, pss[d], e_pass);
        check({tag, "_table"}, tbl[d], e_tbl);
        check({tag, "_fail_mask"}, fmask[d], e_fm);
        check({tag, "_err_count"}, errc[d], e_err);
        check({tag, "_gates_done"}, {gate_a[d], gate_b[d]}, 0);
        if (d == 1) check({tag, "_vec_seq"}, vseq, 8'h1B);
        @(negedge clk);
        check({tag, "_after_done"}, {done[d], busy[d], rv[d]}, 3'b001);
    endtask

    typedef struct {
        logic [7:0]  f0;
        logic [7:0]  f1;
        logic [31:0] tbl;
        logic [7:0]  fm;
        logic [2:0]  ec;
        logic        p;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] m_t;
        logic [7:0]  m_fm;
        logic [2:0]  m_ec;
        logic        m_p;
        int          lat;
        int          d;

        vecs[0] = '{8'h00, 8'h00, 32'h239656EC, 8'h00, 3'd0, 1'b1};
        vecs[1] = '{8'h10, 8'h00, 32'h238646EC, 8'h10, 3'd2, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 32'h239757ED, 8'h01, 3'd3, 1'b0};
        vecs[3] = '{8'h80, 8'h00, 32'h2316566C, 8'h80, 3'd2, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 32'h00000000, 8'hFF, 3'd4, 1'b0};

        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; sa0[i] = 8'h00; sa1[i] = 8'h00;
        end

        // reset asserted at time 0: outputs must already be zero before any edge
        #1;
        check("reset0_dut0", outs(0), 0);
        check("reset0_dut1", outs(1), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // table-driven fault models on both SETTLE configurations
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 2; k++) begin
                sa0[k] = vecs[i].f0;
                sa1[k] = vecs[i].f1;
                sweep(k, -1, $sformatf("vec%0d_d%0d", i, k),
                      vecs[i].tbl, vecs[i].fm, vecs[i].ec, vecs[i].p);
            end
        end
        sa0[0] = 8'h00; sa1[0] = 8'h00; sa0[1] = 8'h00; sa1[1] = 8'h00;

        // start pulsed mid-sweep must not disturb the sweep
        sweep(0, 2, "start_ignored", 32'h239656EC, 8'h00, 3'd0, 1'b1);

        // abort during v=2 SETTLE on the SETTLE=2 instance
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 6) begin
                check("abort_pre_state", {busy[0], gate_a[0], gate_b[0]}, 3'b110);
                abort[0] = 1'b1;
            end
            if (j == 7) begin
                abort[0] = 1'b0;
                check("abort_idle", {busy[0], gate_a[0], gate_b[0], done[0], rv[0], pss[0]}, 0);
            end
        end
        lat = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done[0] || rv[0]) lat++;
        end
        check("abort_no_done", lat, 0);

        // abort coinciding with a SAMPLE exit: that sample is not recorded
        sa0[1] = 8'h10;
        @(negedge clk); start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 2) abort[1] = 1'b1;
            if (j == 3) begin
                abort[1] = 1'b0;
                check("abort_sample_busy", {busy[1], rv[1], done[1]}, 0);
                check("abort_sample_err", errc[1], 1);
                check("abort_sample_fm", fmask[1], 8'h10);
                check("abort_sample_table", tbl[1], 32'h000046EC);
            end
        end
        sa0[1] = 8'h00;

        // start held high: back-to-back sweeps with one IDLE cycle between
        @(negedge clk); start[0] = 1'b1;
        lat = -1;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (done[0]) begin
                lat = j;
                break;
            end
        end
        check("held_latency", lat, 4 * (S0 + 1));
        check("held_pass", {rv[0], pss[0]}, 2'b11);
        @(negedge clk);
        check("held_idle_gap", {busy[0], done[0]}, 0);
        @(negedge clk);
        check("held_relaunch", {busy[0], rv[0], gate_a[0], gate_b[0]}, 4'b1000);
        start[0] = 1'b0;
        lat = -1;
        for (int j = 1; j < 100; j++) begin
            @(negedge clk);
            if (done[0]) begin
                lat = j;
                break;
            end
        end
        check("held_second_latency", lat, 4 * (S0 + 1));
        check("held_second_table", tbl[0], 32'h239656EC);

        // randomized fault models checked against the reference model
        for (int i = 0; i < 16; i++) begin
            d = int'($urandom_range(0, 1));
            sa0[d] = 8'($urandom & $urandom & $urandom);
            sa1[d] = 8'($urandom & $urandom & $urandom) & ~sa0[d];
            model(sa0[d], sa1[d], m_t, m_fm, m_ec, m_p);
            sweep(d, int'($urandom_range(0, 3)), $sformatf("rnd%0d_d%0d", i, d),
                  m_t, m_fm, m_ec, m_p);
        end
        sa0[0] = 8'h00; sa1[0] = 8'h00; sa0[1] = 8'h00; sa1[1] = 8'h00;

        // reset in the middle of a sweep, away from any clock edge
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("midrst_was_busy", busy[0], 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_dut0", outs(0), 0);
        check("midrst_dut1", outs(1), 0);
        @(negedge clk); rst = 1'b0;
        sweep(0, -1, "after_rst", 32'h239656EC, 8'h00, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
